// File: rtl/iter_fixed_point_div.sv
// Signed fixed-point divider: restoring division, one quotient bit per clock, one operation in flight.
// The result is rounded (or truncated), then saturated; overflow flags saturation or a zero divisor.
module iter_fixed_point_div #(
  parameter int WIIA  = 8,
  parameter int WIFA  = 8,
  parameter int WIIB  = 8,
  parameter int WIFB  = 8,
  parameter int WOI   = 12,
  parameter int WOF   = 6,
  parameter int ROUND = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIIA+WIFA-1:0] ina,
  input  logic [WIIB+WIFB-1:0] inb,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WOI+WOF-1:0]   out,
  output logic                 overflow
);

  localparam int WA   = WIIA + WIFA;
  localparam int WB   = WIIB + WIFB;
  localparam int WO   = WOI + WOF;
  localparam int S    = WOF + WIFB - WIFA + 1;
  localparam int NB   = WA + S;
  localparam int CW   = ((NB > WO) ? NB : WO) + 1;
  localparam int CNTW = $clog2(NB + 1);

  localparam logic [CW-1:0] LIM_NEG  = {{(CW-1){1'b0}}, 1'b1} << (WO - 1);
  localparam logic [CW-1:0] LIM_POS  = LIM_NEG - {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WO-1:0] MAX_POS  = {1'b0, {(WO-1){1'b1}}};
  localparam logic [WO-1:0] MOST_NEG = {1'b1, {(WO-1){1'b0}}};

  generate
    if (S < 0) begin : g_bad_shift
      $error("iter_fixed_point_div: WOF+WIFB-WIFA+1 must be non-negative");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, POST = 2'd2, DONE = 2'd3} state_t;

  state_t            state_q;
  logic [NB-1:0]     num_q;
  logic [NB-1:0]     quo_q;
  logic [WB-1:0]     den_q;
  logic [WB-1:0]     rem_q;
  logic [CNTW-1:0]   cnt_q;
  logic              sign_q;
  logic              neg_a_q;
  logic              dz_q;
  logic [WO-1:0]     out_q;
  logic              ovf_q;
  logic              out_valid_q;
  logic              in_ready_q;

  logic [WA-1:0]     a_abs_s;
  logic [WB-1:0]     b_abs_s;
  logic [WB:0]       rem_sh_s;
  logic [WB:0]       rem_d;
  logic              qbit_d;
  logic [CW-1:0]     mag_s;
  logic [WO-1:0]     out_d;
  logic              ovf_d;

  // Operand magnitudes; the most negative value maps to its exact unsigned magnitude.
  always_comb begin
    a_abs_s = ina;
    b_abs_s = inb;
    if (ina[WA-1]) begin
      a_abs_s = (~ina) + {{(WA-1){1'b0}}, 1'b1};
    end else begin
      a_abs_s = ina;
    end
    if (inb[WB-1]) begin
      b_abs_s = (~inb) + {{(WB-1){1'b0}}, 1'b1};
    end else begin
      b_abs_s = inb;
    end
  end

  // One restoring step: shift in the next numerator bit, subtract the divisor when it fits.
  always_comb begin
    rem_sh_s = {rem_q, num_q[NB-1]};
    rem_d    = rem_sh_s;
    qbit_d   = 1'b0;
    if (rem_sh_s >= {1'b0, den_q}) begin
      rem_d  = rem_sh_s - {1'b0, den_q};
      qbit_d = 1'b1;
    end else begin
      rem_d  = rem_sh_s;
      qbit_d = 1'b0;
    end
  end

  // The quotient carries one guard bit below the output LSB, used for rounding.
  always_comb begin
    mag_s = CW'(quo_q >> 1) + CW'((ROUND != 0) ? quo_q[0] : 1'b0);
    out_d = {WO{1'b0}};
    ovf_d = 1'b0;
    if (dz_q) begin
      out_d = neg_a_q ? MOST_NEG : MAX_POS;
      ovf_d = 1'b1;
    end else if (sign_q) begin
      if (mag_s > LIM_NEG) begin
        out_d = MOST_NEG;
        ovf_d = 1'b1;
      end else begin
        out_d = (~mag_s[WO-1:0]) + {{(WO-1){1'b0}}, 1'b1};
        ovf_d = 1'b0;
      end
    end else begin
      if (mag_s > LIM_POS) begin
        out_d = MAX_POS;
        ovf_d = 1'b1;
      end else begin
        out_d = mag_s[WO-1:0];
        ovf_d = 1'b0;
      end
    end
  end

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      num_q       <= {NB{1'b0}};
      quo_q       <= {NB{1'b0}};
      den_q       <= {WB{1'b0}};
      rem_q       <= {WB{1'b0}};
      cnt_q       <= {CNTW{1'b0}};
      sign_q      <= 1'b0;
      neg_a_q     <= 1'b0;
      dz_q        <= 1'b0;
      out_q       <= {WO{1'b0}};
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q     <= ina[WA-1] ^ inb[WB-1];
            neg_a_q    <= ina[WA-1];
            dz_q       <= (b_abs_s == {WB{1'b0}});
            num_q      <= NB'(a_abs_s) << S;
            den_q      <= b_abs_s;
            rem_q      <= {WB{1'b0}};
            quo_q      <= {NB{1'b0}};
            cnt_q      <= {CNTW{1'b0}};
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          if (cnt_q == CNTW'(NB)) begin
            state_q <= POST;
          end else begin
            rem_q <= rem_d[WB-1:0];
            num_q <= num_q << 1;
            quo_q <= {quo_q[NB-2:0], qbit_d};
            cnt_q <= cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
          end
        end
        POST: begin
          out_q       <= out_d;
          ovf_q       <= ovf_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign overflow  = ovf_q;

endmodule
